// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller behind the CPU MEM stage: latches one
// load/store, stalls the pipeline for WAIT_CYCLES+1 cycles, then commits or faults.
module dmem_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned AQ_W  = ADDR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        type_q, type_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       mem_word;
    logic [31:0]       load_ext;
    logic [31:0]       store_word;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic              bad_c;
    logic              mem_we;
    logic              unused_addr_hi;

    // Address bits above the array are ignored so accesses wrap.
    assign unused_addr_hi = ^addr[31:AQ_W];

    assign word_idx = addr_q[AQ_W-1:2];
    assign mem_word = mem[word_idx];
    assign lane_b   = mem_word[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h   = mem_word[{addr_q[1], 4'b0000} +: 16];

    // Illegal encodings, misalignment, unsigned stores and dual strobes fault.
    always_comb begin
        bad_c = 1'b1;
        case (type_q)
            3'b000:  bad_c = 1'b0;
            3'b001:  bad_c = addr_q[0];
            3'b010:  bad_c = (addr_q[1:0] != 2'b00);
            3'b100:  bad_c = wr_q;
            3'b101:  bad_c = wr_q | addr_q[0];
            default: bad_c = 1'b1;
        endcase
        if (rd_q && wr_q) begin
            bad_c = 1'b1;
        end
    end

    always_comb begin
        load_ext = mem_word;
        case (type_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = mem_word;
        endcase
    end

    // Read-modify-write merge keeps the untouched bytes of the word.
    always_comb begin
        store_word = mem_word;
        case (type_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_r || mem_w) begin
                    addr_d  = addr[AQ_W-1:0];
                    wdata_d = wdata;
                    type_d  = dm_type;
                    rd_d    = mem_r;
                    wr_d    = mem_w;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    if (bad_c) begin
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                    end else if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = load_ext;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Backing array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

    assign rdata = rdata_q;
    assign fault = fault_q;
    assign stall = rst & (((state_q == S_IDLE) & (mem_r | mem_w)) | (state_q == S_BUSY));

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, reset/hold sequences, and
// random accesses checked against a word-array reference model.
module tb_dmem_ctrl;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned NW          = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_type;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [NW];

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
        logic        chk;
        logic [31:0] rd;
        logic        f;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .dm_type(dm_type), .rdata(rdata), .stall(stall), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference: access size in bytes, lane shift, masks; fault rules from the access type.
    task automatic model(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, output logic [31:0] exp_rd, output logic exp_f);
        int unsigned size;
        int unsigned idx;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] v;
        size   = 1 << t[1:0];
        idx    = (a >> 2) % NW;
        sh     = 8 * (a % 4);
        exp_rd = 32'd0;
        exp_f  = (r && w) || (t == 3'd3) || (t == 3'd6) || (t == 3'd7) ||
                 (w && t[2]) || ((a % size) != 0);
        if (exp_f) return;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (w) begin
            mdl[idx] = (mdl[idx] & ~(mask << sh)) | ((d & mask) << sh);
        end else begin
            v = (mdl[idx] >> sh) & mask;
            if (!t[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
            exp_rd = v;
        end
    endtask

    // Drive one request at posedge+1 and count stall cycles up to the DONE cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] t, input bit hold,
                          output logic [31:0] got_rd, output logic got_f, output int n);
        bit done;
        mem_r   = r;
        mem_w   = w;
        addr    = a;
        wdata   = d;
        dm_type = t;
        n       = 0;
        done    = 1'b0;
        got_rd  = 'x;
        got_f   = 1'bx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) begin
                n++;
            end else begin
                got_rd = rdata;
                got_f  = fault;
                done   = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!hold) begin
            mem_r = 1'b0;
            mem_w = 1'b0;
        end
    endtask

    task automatic run(input string name, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t, input bit hold);
        logic [31:0] exp_rd, got_rd;
        logic        exp_f, got_f;
        int          n;
        model(r, w, a, d, t, exp_rd, exp_f);
        access(r, w, a, d, t, hold, got_rd, got_f, n);
        check({name, " stall_cycles"}, 32'(n), 32'(WAIT_CYCLES + 1));
        check({name, " fault"}, 32'(got_f), 32'(exp_f));
        if (exp_f || !w) check({name, " rdata"}, got_rd, exp_rd);
    endtask

    initial begin
        logic [31:0] got_rd, dummy_rd;
        logic        got_f, dummy_f;
        int          n;

        vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'h8000_00FF, 3'd2, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,         3'd2, 1'b1, 32'h8000_00FF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h13,   32'h0,         3'd0, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h13,   32'h0,         3'd4, 1'b1, 32'h0000_0080, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h10,   32'h0,         3'd1, 1'b1, 32'h0000_00FF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h12,   32'h0,         3'd5, 1'b1, 32'h0000_8000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h10,   32'h1122_3344, 3'd2, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h11,   32'h0000_00AB, 3'd0, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h10,   32'h0,         3'd2, 1'b1, 32'h1122_AB44, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h12,   32'h0000_BEEF, 3'd1, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h10,   32'h0,         3'd2, 1'b1, 32'hBEEF_AB44, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h12,   32'h0,         3'd2, 1'b1, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h13,   32'h0000_5555, 3'd1, 1'b1, 32'h0,         1'b1};
        vecs[13] = '{1'b1, 1'b1, 32'h10,   32'h0000_DEAD, 3'd2, 1'b1, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h10,   32'h0,         3'd7, 1'b1, 32'h0,         1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h10,   32'h0,         3'd2, 1'b1, 32'hBEEF_AB44, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h1000, 32'h0000_CAFE, 3'd2, 1'b0, 32'h0,         1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h0,    32'h0,         3'd2, 1'b1, 32'h0000_CAFE, 1'b0};

        rst     = 1'b0;
        mem_r   = 1'b0;
        mem_w   = 1'b0;
        addr    = '0;
        wdata   = '0;
        dm_type = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_r = 1'b1;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        mem_r = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            model(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].t, dummy_rd, dummy_f);
            access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].t, 1'b0, got_rd, got_f, n);
            check($sformatf("vec%0d stall_cycles", i), 32'(n), 32'(WAIT_CYCLES + 1));
            check($sformatf("vec%0d fault", i), 32'(got_f), 32'(vecs[i].f));
            if (vecs[i].chk) check($sformatf("vec%0d rdata", i), got_rd, vecs[i].rd);
        end

        // Reset during BUSY aborts an uncommitted store.
        run("rst_pre_sw", 1'b0, 1'b1, 32'h20, 32'h1111_1111, 3'd2, 1'b0);
        mem_w   = 1'b1;
        addr    = 32'h20;
        wdata   = 32'h1234_5678;
        dm_type = 3'd2;
        @(posedge clk);
        #1;
        #2 rst = 1'b0;
        #1;
        check("rst_busy stall", 32'(stall), 32'd0);
        check("rst_busy rdata", rdata, 32'd0);
        check("rst_busy fault", 32'(fault), 32'd0);
        mem_w = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run("rst_old_word", 1'b1, 1'b0, 32'h20, 32'h0, 3'd2, 1'b0);
        check("rst_old_word model", mdl[8], 32'h1111_1111);

        // Request held through DONE must restart only from IDLE.
        run("hold_first", 1'b1, 1'b0, 32'h10, 32'h0, 3'd2, 1'b1);
        run("hold_second", 1'b1, 1'b0, 32'h10, 32'h0, 3'd2, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run($sformatf("init%0d", i), 1'b0, 1'b1, 32'(i * 4), $urandom, 3'd2, 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            int unsigned sel;
            logic        r, w;
            logic [31:0] a;
            sel = $urandom_range(0, 19);
            r   = (sel < 9) || (sel >= 18);
            w   = (sel >= 9);
            a   = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2) |
                  32'($urandom_range(0, 3));
            run($sformatf("rnd%0d", i), r, w, a, $urandom, 3'($urandom_range(0, 7)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the pipelined CPU's MEM stage.
- Consumes the CPU's mem_r/mem_w, ALU address, store data and access type. Returns sign- or zero-extended load data.
- Models a multi-cycle backing RAM with an internal word array. Holds the pipeline with a stall until each access completes.
- Flags misaligned or illegal accesses instead of performing them.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, number of cycles the RAM stays busy before an access commits; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_r  input  1  load request from the MEM stage.
- mem_w  input  1  store request from the MEM stage.
- addr  input  32  byte address (MEM-stage ALU result).
- wdata  input  32  store data, right-aligned.
- dm_type  input  3  access type, RISC-V funct3 encoding: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- rdata  output  32  extended load data; valid in the DONE cycle and held until the next access.
- stall  output  1  asserted while an access is in flight; freezes the CPU pipeline.
- fault  output  1  one-cycle pulse in DONE for a misaligned or illegal access.

Behaviour:
Reset:
- While rst is low, state is IDLE, rdata=0, stall=0, fault=0 and the wait counter is 0.
- Array contents are not cleared by reset.
- Reset mid-access aborts the access. A store not yet committed never writes.

State machine:
- IDLE: if mem_r or mem_w is high, stall is driven high combinationally in the same cycle.
  - Latch addr, wdata, dm_type and op.
  - Load the counter with WAIT_CYCLES-1 and go to BUSY.
- BUSY: stall=1.
  - Counter>0: decrement.
  - Counter==0: commit the access (write the array, or capture the extended read into rdata) and go to DONE.
- DONE: stall=0. fault pulses if the latched access was faulty.
  - Next cycle goes to IDLE unconditionally.
  - Requests seen in DONE are ignored; they belong to the departing instruction.

Timing:
- A request first seen in IDLE at cycle t keeps stall high for cycles t..t+WAIT_CYCLES.
- rdata is valid and stall is low at cycle t+WAIT_CYCLES+1.
- Back-to-back accesses are separated by at least one IDLE cycle.
- While stalled, the requester holds its inputs stable. The controller uses only the latched copies.

Simultaneous requests:
- mem_r and mem_w both high is an illegal access (fault, no write, rdata=0).

Addressing and lanes:
- Word index is addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the array size.
- Byte lane is addr[1:0]; half lane is addr[1].
- Stores modify only the addressed byte or half; other bytes are preserved.
- Loads select the lane, then sign-extend (000/001) or zero-extend (100/101).

Faults (no write, rdata=0, same latency as a normal access):
- Half access with addr[0]=1.
- Word access with addr[1:0]!=0.
- dm_type of 011, 110 or 111.
- Store with dm_type 100 or 101.

Test Plan:
1. WAIT_CYCLES=2. sw 0x8000_00FF to addr 0x10, then lw from 0x10.
   - Each access holds stall high for exactly 3 cycles.
   - rdata=0x8000_00FF in the DONE cycle.
2. Word 0x10 = 0x8000_00FF.
   - lb from 0x13 -> rdata=0xFFFF_FF80.
   - lbu from 0x13 -> 0x0000_0080.
   - lh from 0x10 -> 0x0000_00FF.
   - lhu from 0x12 -> 0x0000_8000.
3. sb 0xAB to 0x11 over word 0x1122_3344 -> next lw from 0x10 returns 0x1122_AB44.
   - sh 0xBEEF to 0x12 -> lw returns 0xBEEF_AB44.
4. Fault cases: lw from 0x12, sh to 0x13, both strobes high, dm_type 111.
   - Each gives fault=1 for one cycle in DONE and rdata=0.
   - The target word is unchanged on a later lw.
5. sw 0x1234_5678 issued; rst driven low during BUSY.
   - stall, rdata and fault drop immediately.
   - A later lw shows the old word.
   - With ADDR_W=10, sw to 0x1000 is read back by lw from 0x0000 (wrap).
6. Request held high through DONE.
   - No second access starts; stall is low in DONE.
   - A new access starts only from IDLE on the following cycle.
